mram_serial_host: RTL and testbench
===================================

Name: mram_serial_host

Overview:
- Host-side sequencer that sits directly upstream of the MRAM top module.
- Accepts one parallel command (read/write, word select, 20-bit address, 16-bit write data) over a valid/ready handshake.
- Shifts address and data out serially, MSB first, and drives read_write_sel. For reads, it deserialises the returned serial word into a parallel response.
- Gives the MRAM path a simple parallel command/response interface.

Parameters:
- ADDR_W, 20, serial address length in bits; also the SHIFT phase length in cycles.
- DATA_W, 16, data word width; also the CAPTURE phase length in cycles. Must satisfy DATA_W <= ADDR_W.
- ACCESS_CYC, 4, idle cycles between end of SHIFT and start of CAPTURE (MRAM access window). Must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_word_sel  in  2  00 full word, 01 lower byte, 10 upper byte, 11 treated as 00
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  read data (0 for writes)
- ser_addr  out  1  serial address stream to the MRAM top addr_in
- ser_data  out  1  serial data stream to the MRAM top data_in
- read_write_sel  out  3  {word_sel[1:0], write} to the MRAM top
- ser_rd_in  in  1  serial read data from the MRAM top ser_data_out
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst low, asynchronous): state = IDLE. cmd_ready=1, rsp_valid=0, rsp_rdata=0, ser_addr=0, ser_data=0, read_write_sel=3'b000, busy=0. All counters and shift registers are cleared.
- Reset asserted mid-operation aborts the command with no response; the stage resumes in IDLE after release.
- Internal states: IDLE, SHIFT, ACCESS, CAPTURE, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch addr, wdata, write and word_sel (11 remapped to 00), then go to SHIFT.
  - cmd_ready is 0 in every other state, so a command arriving in the DONE handshake cycle is accepted the following cycle at the earliest.
- read_write_sel:
  - Driven from latched fields from the cycle after accept through DONE.
  - Returns to 3'b000 in IDLE.
- SHIFT, exactly ADDR_W cycles (counter 0..ADDR_W-1):
  - ser_addr = addr[ADDR_W-1-cnt].
  - ser_data is right-aligned: 0 for cnt < ADDR_W-DATA_W, then wdata MSB first, so the wdata LSB coincides with the addr LSB on the last cycle.
  - For reads, ser_data = 0 throughout.
  - Go to ACCESS after the last bit.
- ACCESS, exactly ACCESS_CYC cycles:
  - ser_addr=ser_data=0.
  - Then go to CAPTURE if read, DONE if write.
- CAPTURE, exactly DATA_W cycles:
  - Sample ser_rd_in each cycle into a left-shift register; the first sampled bit ends as rdata[DATA_W-1].
  - Go to DONE.
- DONE:
  - rsp_valid=1. rsp_rdata holds captured data for reads, 0 for writes. Both stay stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid. rsp_rdata retains its value.
- Latency, counting accept at cycle 0:
  - rsp_valid first high at cycle 1+ADDR_W+ACCESS_CYC for writes (25 at defaults).
  - rsp_valid first high at cycle 1+ADDR_W+ACCESS_CYC+DATA_W for reads (41 at defaults).
- Counter width is $clog2 of the largest phase length. No wrap-around: every phase ends on its terminal count.

Optional Feature:
- Macro: MRAM_HOST_BYTE_MASK_EN.
- Defined: for reads, rsp_rdata is masked by word_sel.
  - 01: {8'h00, rdata[7:0]}.
  - 10: {8'h00, rdata[15:8]}, i.e. the upper byte is returned right-justified.
  - 00: unmasked.
- Undefined: rsp_rdata is always the raw captured DATA_W bits regardless of word_sel.

Test Plan:
- Reset mid-SHIFT of a write (cycle 7) -> all outputs return to reset values immediately. No rsp_valid ever appears. The next command is accepted normally.
- Write addr=20'hA5F0F, wdata=16'hBEEF, sel=00 -> ser_addr carries the 20 bits of A5F0F MSB first. ser_data carries 4 zeros then BEEF MSB first. read_write_sel=3'b001. rsp_valid appears at cycle 25 with rsp_rdata=0.
- Read addr=20'h00010, sel=00, bench drives ser_rd_in with 16'h1234 MSB first during CAPTURE -> rsp_valid appears at cycle 41 with rsp_rdata=16'h1234. ser_data stays 0 throughout. read_write_sel=3'b000.
- Read sel=10 returning 16'hAB12 -> rsp_rdata=16'h00AB with MRAM_HOST_BYTE_MASK_EN defined, 16'hAB12 without it. read_write_sel=3'b100.
- Backpressure: rsp_ready held low for 10 cycles after rsp_valid -> rsp_valid and rsp_rdata remain stable, cmd_ready stays 0, and cmd_valid is ignored. After the handshake, cmd_ready=1 in the next cycle.
- Back-to-back commands with cmd_valid held high: write then read -> the second command is accepted exactly 1 cycle after the first response handshake, and both responses are correct.

Source files
------------

// File: rtl/mram_serial_host.sv
// mram_serial_host
//   Host-side sequencer placed directly upstream of the MRAM top module.
//   One parallel command is accepted over a valid/ready handshake. The
//   address (and write data, right-aligned) is shifted out serially MSB
//   first, an access window is waited out, and for reads the returned serial
//   word is deserialised into a parallel response.
//
//   Phases after accept: SHIFT (ADDR_W cycles), ACCESS (ACCESS_CYC cycles),
//   CAPTURE (DATA_W cycles, reads only), then DONE until rsp_ready.
//
// Optional build macro:
//   MRAM_HOST_BYTE_MASK_EN - when defined, read responses are masked by
//   word_sel (01: low byte, 10: high byte right-justified, 00: full word).
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write      1 = write, 0 = read
//   cmd_word_sel   00 full, 01 low byte, 10 high byte, 11 treated as 00
//   cmd_addr       target address (ADDR_W bits)
//   cmd_wdata      write data (DATA_W bits)
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata      read data (0 for writes)
//   ser_addr       serial address to MRAM addr_in
//   ser_data       serial write data to MRAM data_in
//   read_write_sel {word_sel, write} to MRAM
//   ser_rd_in      serial read data from MRAM ser_data_out
//   busy           high whenever the sequencer is not idle
module mram_serial_host #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ACCESS_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_word_sel,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ser_addr,
  output logic              ser_data,
  output logic [2:0]        read_write_sel,
  input  logic              ser_rd_in,
  output logic              busy
);

  localparam int unsigned MAX_LEN = (ADDR_W > ACCESS_CYC) ? ADDR_W : ACCESS_CYC;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] ACCESS_LAST  = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] CAPTURE_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    ACCESS,
    CAPTURE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  logic [ADDR_W-1:0]  addr_sh;
  logic [ADDR_W-1:0]  data_sh;
  logic               write_q;
  logic [1:0]         sel_q;
  logic [DATA_W-1:0]  rdata_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and phase counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACCESS: begin
        if (cnt_q == ACCESS_LAST) begin
          state_d = write_q ? DONE : CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        if (cnt_q == CAPTURE_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath. Write data is loaded zero-extended into an ADDR_W-wide shift
  // register alongside the address, so both streams leave MSB first and the
  // data LSB lines up with the address LSB without any index arithmetic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_sh <= '0;
      data_sh <= '0;
      write_q <= 1'b0;
      sel_q   <= 2'b00;
      rdata_q <= '0;
    end else if (accept) begin
      addr_sh <= cmd_addr;
      data_sh <= cmd_write ? ADDR_W'(cmd_wdata) : '0;
      write_q <= cmd_write;
      sel_q   <= (cmd_word_sel == 2'b11) ? 2'b00 : cmd_word_sel;
      rdata_q <= '0;
    end else if (state_q == SHIFT) begin
      addr_sh <= addr_sh << 1;
      data_sh <= data_sh << 1;
    end else if (state_q == CAPTURE) begin
      rdata_q <= {rdata_q[DATA_W-2:0], ser_rd_in};
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign rsp_valid      = (state_q == DONE);
  assign ser_addr       = (state_q == SHIFT) ? addr_sh[ADDR_W-1] : 1'b0;
  assign ser_data       = (state_q == SHIFT) ? data_sh[ADDR_W-1] : 1'b0;
  assign read_write_sel = (state_q != IDLE) ? {sel_q, write_q} : 3'b000;

  // rdata_q is cleared on every accept, so writes always report zero and the
  // last response value persists through IDLE.
`ifdef MRAM_HOST_BYTE_MASK_EN
  localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);

  always_comb begin
    rsp_rdata = rdata_q;
    if (!write_q) begin
      case (sel_q)
        2'b01:   rsp_rdata = rdata_q & BYTE_MASK;
        2'b10:   rsp_rdata = (rdata_q >> 8) & BYTE_MASK;
        default: rsp_rdata = rdata_q;
      endcase
    end
  end
`else
  always_comb begin
    rsp_rdata = rdata_q;
  end
`endif

endmodule

// File: tb/tb_mram_serial_host.sv
module tb_mram_serial_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_word_sel;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        ser_addr;
  logic        ser_data;
  logic [2:0]  read_write_sel;
  logic        ser_rd_in;
  logic        busy;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  mram_serial_host #(
    .ADDR_W    (20),
    .DATA_W    (16),
    .ACCESS_CYC(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_word_sel  (cmd_word_sel),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .ser_addr      (ser_addr),
    .ser_data      (ser_data),
    .read_write_sel(read_write_sel),
    .ser_rd_in     (ser_rd_in),
    .busy          (busy)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sel;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd_word;
    logic [2:0]  rws;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues a command at the current cycle (cycle 0) and walks it to DONE,
  // checking the serial streams, the access window and exact response latency.
  task automatic run_to_done(input vec_t v);
    logic [19:0] a_seen;
    logic [19:0] d_seen;
    logic [15:0] rd_sh;
    int unsigned early;
    int unsigned nz;
    cmd_write    = v.wr;
    cmd_word_sel = v.sel;
    cmd_addr     = v.addr;
    cmd_wdata    = v.wdata;
    cmd_valid    = 1'b1;
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    a_seen = '0;
    d_seen = '0;
    early  = 0;
    nz     = 0;
    chk("rws_shift", 32'(read_write_sel), 32'(v.rws));
    for (int i = 0; i < 20; i++) begin
      a_seen = {a_seen[18:0], ser_addr};
      d_seen = {d_seen[18:0], ser_data};
      if (rsp_valid) early++;
      step();
    end
    chk("ser_addr_stream", 32'(a_seen), 32'(v.addr));
    chk("ser_data_stream", 32'(d_seen), v.wr ? 32'(v.wdata) : 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (ser_addr || ser_data) nz++;
      if (rsp_valid) early++;
      step();
    end
    chk("access_quiet", 32'(nz), 32'd0);
    if (!v.wr) begin
      rd_sh = v.rd_word;
      for (int i = 0; i < 16; i++) begin
        ser_rd_in = rd_sh[15];
        rd_sh     = rd_sh << 1;
        if (rsp_valid) early++;
        step();
      end
      ser_rd_in = 1'b0;
    end
    chk("rsp_early", 32'(early), 32'd0);
    chk("rsp_valid_at_latency", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", 32'(rsp_rdata), 32'(v.rdata));
    chk("rws_done", 32'(read_write_sel), 32'(v.rws));
    chk("busy_done", 32'(busy), 32'd1);
  endtask

  task automatic handshake(input logic [15:0] exp_rdata);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hs_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("hs_rws_idle", 32'(read_write_sel), 32'd0);
    chk("hs_rdata_kept", 32'(rsp_rdata), 32'(exp_rdata));
  endtask

  initial begin
    logic [15:0] held;
    int unsigned bad;

    vecs[0] = '{1'b1, 2'b00, 20'hA5F0F, 16'hBEEF, 16'h0000, 3'b001, 16'h0000};
    vecs[1] = '{1'b0, 2'b00, 20'h00010, 16'h0000, 16'h1234, 3'b000, 16'h1234};
`ifdef MRAM_HOST_BYTE_MASK_EN
    vecs[2] = '{1'b0, 2'b10, 20'h12345, 16'h0000, 16'hAB12, 3'b100, 16'h00AB};
    vecs[3] = '{1'b0, 2'b01, 20'h54321, 16'h0000, 16'hAB12, 3'b010, 16'h0012};
`else
    vecs[2] = '{1'b0, 2'b10, 20'h12345, 16'h0000, 16'hAB12, 3'b100, 16'hAB12};
    vecs[3] = '{1'b0, 2'b01, 20'h54321, 16'h0000, 16'hAB12, 3'b010, 16'hAB12};
`endif
    vecs[4] = '{1'b0, 2'b11, 20'h80001, 16'h0000, 16'h5A5A, 3'b000, 16'h5A5A};
    vecs[5] = '{1'b1, 2'b10, 20'hFFFFF, 16'h0001, 16'h0000, 3'b101, 16'h0000};

    rst          = 1'b0;
    cmd_valid    = 1'b0;
    cmd_write    = 1'b0;
    cmd_word_sel = 2'b00;
    cmd_addr     = '0;
    cmd_wdata    = '0;
    rsp_ready    = 1'b0;
    ser_rd_in    = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_ser", 32'({ser_addr, ser_data}), 32'd0);
    chk("rst_rws", 32'(read_write_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_to_done(vecs[i]);
      handshake(vecs[i].rdata);
    end

    // Reset during SHIFT of a write, at cycle 7 after accept.
    run_to_done(vecs[1]);
    handshake(vecs[1].rdata);
    cmd_write    = 1'b1;
    cmd_word_sel = 2'b00;
    cmd_addr     = 20'hA5F0F;
    cmd_wdata    = 16'hBEEF;
    cmd_valid    = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rws", 32'(read_write_sel), 32'd0);
    chk("mid_rst_ser", 32'({ser_addr, ser_data}), 32'd0);
    chk("mid_rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
    step();
    step();
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid || busy) bad++;
      step();
    end
    chk("no_rsp_after_abort", 32'(bad), 32'd0);
    run_to_done(vecs[0]);
    handshake(vecs[0].rdata);

    // Backpressure: response held for 10 cycles while a command is offered.
    run_to_done(vecs[2]);
    held = rsp_rdata;
    bad  = 0;
    cmd_write    = 1'b1;
    cmd_addr     = 20'h0F0F0;
    cmd_wdata    = 16'h7777;
    cmd_valid    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_rdata !== held || cmd_ready) bad++;
      step();
    end
    chk("bp_stable", 32'(bad), 32'd0);
    chk("bp_still_valid", 32'(rsp_valid), 32'd1);
    cmd_valid = 1'b0;
    handshake(vecs[2].rdata);
    step();
    chk("bp_cmd_ignored", 32'(busy), 32'd0);

    // Back-to-back: write then read with cmd_valid held through the handshake.
    run_to_done(vecs[5]);
    cmd_write    = vecs[1].wr;
    cmd_word_sel = vecs[1].sel;
    cmd_addr     = vecs[1].addr;
    cmd_wdata    = vecs[1].wdata;
    cmd_valid    = 1'b1;
    rsp_ready    = 1'b1;
    chk("b2b_ready_in_done", 32'(cmd_ready), 32'd0);
    step();
    rsp_ready = 1'b0;
    chk("b2b_ready_next", 32'(cmd_ready), 32'd1);
    run_to_done(vecs[1]);
    handshake(vecs[1].rdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
